// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode enum, memory loader FSM state and
// address-decode constants used by the instruction/data memory.
package mips_pkg;

  // Primary opcodes (instr[31:26]) used by the core.
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDIU = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_t;

  // Memory state: core ports live in IDLE, program loader owns the array in LOAD.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } mem_state_t;

  localparam int ADDR_W     = 32;
  localparam int BYTE_OFF_W = 2;   // byte offset bits inside a 32-bit word

  function automatic logic word_aligned(input logic [ADDR_W-1:0] addr);
    return addr[BYTE_OFF_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/mips_sram.sv
// Word array: one write port, two synchronous read-first read ports, no reset.
// Ports: clk; we/waddr/wdata write port; raddr_a/rdata_a and raddr_b/rdata_b
// registered read ports (a read and a write to the same word in one cycle
// return the old contents).
module mips_sram #(
  parameter int depth_words = 1024,
  parameter int aw          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [aw-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [aw-1:0] raddr_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem [depth_words];

  // Non-blocking write and read in the same block give read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/mips_memory.sv
// Unified MIPS instruction/data memory with a streaming program loader.
// Ports: clk, reset (sync, active high); instr_addr -> instr_in fetch port;
// data_addr/data_rd_wr/data_out -> data_in data port (1-cycle read latency);
// ld_start/ld_valid/ld_last/ld_data with ld_ready loader handshake;
// busy while loading; err sticky flag for bad core accesses or load overflow.
module mips_memory
  import mips_pkg::*;
#(
  parameter int          depth_words = 1024,
  parameter logic [31:0] base_addr   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic        data_rd_wr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic        ld_last,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        busy,
  output logic        err
);

  localparam int          aw   = $clog2(depth_words);
  localparam logic [32:0] span = 33'(depth_words) << BYTE_OFF_W;

  mem_state_t    state;
  logic [aw-1:0] ptr;
  logic          i_vld, d_vld;
  logic [31:0]   i_rd, d_rd;

  // Offsets wrap for addresses below base_addr, so one unsigned compare
  // covers both range ends. base_addr is word aligned, so offset alignment
  // equals address alignment.
  logic [31:0]   i_off, d_off;
  logic          i_ok, d_ok;
  logic [aw-1:0] i_idx, d_idx;

  assign i_off = instr_addr - base_addr;
  assign d_off = data_addr - base_addr;
  assign i_ok  = ({1'b0, i_off} < span) && word_aligned(i_off);
  assign d_ok  = ({1'b0, d_off} < span) && word_aligned(d_off);
  assign i_idx = i_off[aw+BYTE_OFF_W-1:BYTE_OFF_W];
  assign d_idx = d_off[aw+BYTE_OFF_W-1:BYTE_OFF_W];

  // A restart pulse in LOAD drops any beat presented in the same cycle.
  logic ld_fire, ptr_end, core_we, we;
  logic [aw-1:0] waddr;
  logic [31:0]   wdata;

  assign ld_fire = (state == ST_LOAD) && ld_valid && !ld_start;
  assign ptr_end = ptr == aw'(depth_words - 1);
  assign core_we = (state == ST_IDLE) && !data_rd_wr && d_ok;
  assign we      = !reset && (ld_fire || core_we);
  assign waddr   = ld_fire ? ptr : d_idx;
  assign wdata   = ld_fire ? ld_data : data_out;

  mips_sram #(.depth_words(depth_words), .aw(aw)) u_sram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (i_idx),
    .rdata_a (i_rd),
    .raddr_b (d_idx),
    .rdata_b (d_rd)
  );

  // i_vld/d_vld qualify the registered read data: cleared for bad addresses
  // and for any read launched while the loader owns (or is taking) the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      err   <= 1'b0;
      i_vld <= 1'b0;
      d_vld <= 1'b0;
    end else begin
      i_vld <= (state == ST_IDLE) && !ld_start && i_ok;
      d_vld <= (state == ST_IDLE) && !ld_start && d_ok;
      if ((state == ST_IDLE) && (!i_ok || !d_ok)) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            state <= ST_LOAD;
            ptr   <= '0;
          end
        end
        ST_LOAD: begin
          if (ld_start) begin
            ptr <= '0;
          end else if (ld_valid) begin
            ptr <= ptr + 1'b1;
            if (ld_last || ptr_end) state <= ST_IDLE;
            if (ptr_end && !ld_last) err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign instr_in = i_vld ? i_rd : 32'h0;
  assign data_in  = d_vld ? d_rd : 32'h0;
  assign busy     = state == ST_LOAD;
  assign ld_ready = state == ST_LOAD;

endmodule

// File: tb/tb_mips_memory.sv
// Directed bench: main instance (64 words, base 0x00400000) for loader,
// read/write, read-first and bad-access cases; small instance (4 words,
// base 0) for overflow and reset-during-load.
module tb_mips_memory;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic [31:0] instr_addr = BASE, data_addr = BASE, data_out = '0, ld_data = '0;
  logic        data_rd_wr = 1'b1, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] instr_in, data_in;
  logic        ld_ready, busy, err;

  // small instance signals
  logic [31:0] s_instr_addr = '0, s_data_addr = '0, s_data_out = '0, s_ld_data = '0;
  logic        s_data_rd_wr = 1'b1, s_ld_start = 1'b0, s_ld_valid = 1'b0, s_ld_last = 1'b0;
  logic [31:0] s_instr_in, s_data_in;
  logic        s_ld_ready, s_busy, s_err;

  mips_memory #(.depth_words(64), .base_addr(BASE)) dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_in(instr_in),
    .data_addr(data_addr), .data_rd_wr(data_rd_wr), .data_out(data_out), .data_in(data_in),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data),
    .ld_ready(ld_ready), .busy(busy), .err(err)
  );

  mips_memory #(.depth_words(4), .base_addr(32'h0)) dut4 (
    .clk(clk), .reset(reset),
    .instr_addr(s_instr_addr), .instr_in(s_instr_in),
    .data_addr(s_data_addr), .data_rd_wr(s_data_rd_wr), .data_out(s_data_out), .data_in(s_data_in),
    .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_last(s_ld_last), .ld_data(s_ld_data),
    .ld_ready(s_ld_ready), .busy(s_busy), .err(s_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // fetch one word of the small instance through its instruction port
  task automatic fetch4(input string tag, input int idx, input logic [31:0] exp);
    s_instr_addr = 32'(idx * 4);
    step();
    chk(tag, s_instr_in, exp);
  endtask

  localparam logic [31:0] A [5] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222,
                                   32'hA333_3333, 32'hA444_4444};
  localparam logic [31:0] B [4] = '{32'hB000_0000, 32'hB111_1111, 32'hB222_2222,
                                   32'hB333_3333};

  initial begin
    // reset state
    step(); step();
    chk("rst_instr_in", instr_in, 32'h0);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b0;

    // program load: 3 beats, ld_last on the third
    step();
    ld_start = 1'b1;
    step();
    chk("ld_busy1", 32'(busy), 32'h1);
    chk("ld_ready1", 32'(ld_ready), 32'h1);
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h2402_0005;
    step();
    chk("ld_busy2", 32'(busy), 32'h1);
    chk("ld_instr_zero", instr_in, 32'h0);
    ld_data = 32'h2403_0007;
    step();
    chk("ld_busy3", 32'(busy), 32'h1);
    ld_data = 32'h0043_2021; ld_last = 1'b1;
    step();
    chk("ld_done_busy", 32'(busy), 32'h0);
    chk("ld_done_ready", 32'(ld_ready), 32'h0);
    ld_valid = 1'b0; ld_last = 1'b0;
    instr_addr = BASE + 32'h8;
    step();
    chk("fetch_w2", instr_in, 32'h0043_2021);

    // write then read
    data_addr = BASE + 32'h40; data_rd_wr = 1'b0; data_out = 32'hDEAD_BEEF;
    step();
    data_rd_wr = 1'b1;
    step();
    chk("wr_rd", data_in, 32'hDEAD_BEEF);
    chk("wr_rd_err", 32'(err), 32'h0);

    // read-first on the instruction port
    data_addr = BASE + 32'h10; data_rd_wr = 1'b0; data_out = 32'h2222_2222;
    step();
    data_out = 32'h1111_1111; instr_addr = BASE + 32'h10;
    step();
    chk("rdfirst_old", instr_in, 32'h2222_2222);
    data_rd_wr = 1'b1;
    step();
    chk("rdfirst_new", instr_in, 32'h1111_1111);

    // misaligned write, then out-of-range write
    data_addr = BASE + 32'h41; data_rd_wr = 1'b0; data_out = 32'hBAD0_BAD0;
    step();
    chk("misalign_err", 32'(err), 32'h1);
    chk("misalign_data", data_in, 32'h0);
    data_addr = BASE + 32'h100;
    step();
    chk("range_err", 32'(err), 32'h1);
    chk("range_data", data_in, 32'h0);
    data_addr = BASE + 32'h40; data_rd_wr = 1'b1; instr_addr = BASE;
    step();
    chk("misalign_nowrite", data_in, 32'hDEAD_BEEF);
    chk("range_nowrite", instr_in, 32'h2402_0005);
    step();
    chk("err_sticky", 32'(err), 32'h1);
    reset = 1'b1;
    step();
    chk("err_cleared", 32'(err), 32'h0);
    chk("rst_data_zero", data_in, 32'h0);
    reset = 1'b0;

    // overflow on the 4-word instance: 5 beats, no ld_last
    s_ld_start = 1'b1;
    step();
    s_ld_start = 1'b0; s_ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_ld_data = A[i];
      step();
    end
    chk("ovf_busy", 32'(s_busy), 32'h0);
    chk("ovf_err", 32'(s_err), 32'h1);
    chk("ovf_ready", 32'(s_ld_ready), 32'h0);
    s_ld_data = A[4];
    step();
    s_ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) fetch4($sformatf("ovf_w%0d", i), i, A[i]);

    // reset after 2 of 4 beats
    s_instr_addr = '0;
    s_ld_start = 1'b1;
    step();
    s_ld_start = 1'b0; s_ld_valid = 1'b1; s_ld_data = B[0];
    step();
    s_ld_data = B[1];
    step();
    s_ld_data = B[2]; reset = 1'b1;
    step();
    chk("abort_busy", 32'(s_busy), 32'h0);
    chk("abort_err", 32'(s_err), 32'h0);
    reset = 1'b0; s_ld_valid = 1'b0;
    fetch4("abort_w0", 0, B[0]);
    fetch4("abort_w1", 1, B[1]);
    fetch4("abort_w2", 2, A[2]);
    fetch4("abort_w3", 3, A[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
